reciprocal_seq: RTL and testbench

//  Multi-cycle signed fixed-point reciprocal (1/x) for the raycaster's distance/step maths.

---
 rtl/reciprocal_seq_if.sv | 22 ++
 rtl/reciprocal_seq.sv | 163 ++++++++++++++++
 tb/tb_reciprocal_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/reciprocal_seq_if.sv
// Handshake bundle for reciprocal_seq: operand request channel and result channel.
// The producer/consumer side uses master; the reciprocal unit uses slave.
interface reciprocal_seq_if #(parameter int W = 24);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sat;
  logic         out_div0;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_div0
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_div0
  );
endinterface

// File: rtl/reciprocal_seq.sv
// Multi-cycle signed Qm.n reciprocal: normalise, linear seed, Newton-Raphson, denormalise.
// Includes the lzc leading-zero counter used for normalisation.
module lzc #(
  parameter  int WIDTH = 24,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_cnt
);
  // Highest set bit wins because it is visited last.
  always_comb begin
    o_cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (i_data[i]) o_cnt = CW'(WIDTH - 1 - i);
  end
endmodule

module reciprocal_seq #(
  parameter int Q_M   = 12,
  parameter int Q_N   = 12,
  parameter int ITERS = 3
) (
  input  logic              clk,
  input  logic              reset,
  reciprocal_seq_if.slave   bus
);
  localparam int W  = Q_M + Q_N;
  localparam int YW = W + 2;
  localparam int RW = 2 * W + 4;
  localparam int ZW = $clog2(W + 1);

  // Seed line 48/17 - 32/17*d, constants rounded to nearest in Q2.W.
  localparam logic [YW-1:0] C1  = YW'(((64'd48 << W) + 64'd8) / 64'd17);
  localparam logic [YW-1:0] C2  = YW'(((64'd32 << W) + 64'd8) / 64'd17);
  localparam logic [YW-1:0] TWO = YW'(2) << W;
  localparam logic [W-1:0]  MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_SEED, S_ITER, S_DENORM, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic            r_sign;
  logic [W-1:0]    r_a;
  logic [ZW-1:0]   r_z;
  logic [W-1:0]    r_d;
  logic [YW-1:0]   r_y;
  logic [YW-1:0]   r_e;
  logic            r_phase;
  logic [1:0]      r_iter;
  logic            r_div0;
  logic [W-1:0]    r_out_data;
  logic            r_out_sat;
  logic            r_out_div0;

  logic [ZW-1:0]     w_z;
  logic [W+YW-1:0]   w_dy;
  logic [2*YW-1:0]   w_yt;
  logic [W+YW-1:0]   w_c2d;
  logic [YW-1:0]     w_seed;
  int                w_s;
  logic [RW-1:0]     w_mag;
  logic [RW-1:0]     w_lim;
  logic              w_sat;
  logic [W-1:0]      w_res;

  lzc #(.WIDTH(W)) u_lzc (.i_data(r_a), .o_cnt(w_z));

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_div0  = r_out_div0;

  assign w_dy   = (W+YW)'(r_d) * (W+YW)'(r_y);
  assign w_yt   = (2*YW)'(r_y) * (2*YW)'(TWO - r_e);
  assign w_c2d  = (W+YW)'(C2) * (W+YW)'(r_d);
  assign w_seed = C1 - YW'(w_c2d >> W);

  // Magnitude r = y * 2^-(2*Q_M - z); a wide shift keeps every bit so the
  // saturation compare also catches bits that a W-bit left shift would drop.
  always_comb begin
    w_s   = 2 * Q_M - int'(r_z);
    w_mag = (w_s >= 0) ? (RW'(r_y) >> w_s) : (RW'(r_y) << (-w_s));
    w_lim = r_sign ? (RW'(1) << (W - 1)) : ((RW'(1) << (W - 1)) - RW'(1));
    w_sat = r_div0 || (w_mag > w_lim);
    if (w_sat)
      w_res = (r_sign && !r_div0) ? MINV : MAXV;
    else if (r_sign)
      w_res = ~w_mag[W-1:0] + W'(1);
    else
      w_res = w_mag[W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A zero operand is flagged in NORM and SEED then bypasses the iterations.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid) w_next = S_NORM;
      S_NORM:   w_next = S_SEED;
      S_SEED:   w_next = r_div0 ? S_DENORM : S_ITER;
      S_ITER:   if (r_phase && (r_iter == 2'(ITERS - 1))) w_next = S_DENORM;
      S_DENORM: w_next = S_DONE;
      S_DONE:   if (bus.out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign     <= 1'b0;
      r_a        <= '0;
      r_z        <= '0;
      r_d        <= '0;
      r_y        <= '0;
      r_e        <= '0;
      r_phase    <= 1'b0;
      r_iter     <= '0;
      r_div0     <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_out_div0 <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_sign <= bus.in_data[W-1];
          r_a    <= bus.in_data[W-1] ? (~bus.in_data + W'(1)) : bus.in_data;
        end
        S_NORM: begin
          r_z    <= w_z;
          r_d    <= r_a << w_z;
          r_div0 <= (r_a == '0);
        end
        S_SEED: begin
          r_y     <= w_seed;
          r_phase <= 1'b0;
          r_iter  <= '0;
        end
        S_ITER: begin
          if (!r_phase) begin
            r_e <= YW'(w_dy >> W);
          end else begin
            r_y    <= YW'(w_yt >> W);
            r_iter <= r_iter + 2'd1;
          end
          r_phase <= ~r_phase;
        end
        S_DENORM: begin
          r_out_data <= w_res;
          r_out_sat  <= w_sat;
          r_out_div0 <= r_div0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reciprocal_seq.sv
// Randomised and directed bench for reciprocal_seq against a real-arithmetic 1/x model.
module tb_reciprocal_seq;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  reciprocal_seq_if #(.W(W)) bus ();

  reciprocal_seq #(.Q_M(12), .Q_N(12), .ITERS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
    longint dd;
    n_chk++;
    dd = got - exp;
    if (dd < 0) dd = -dd;
    if (dd > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Exact 1/x in units of 2^-12, clamped to the Q12.12 range and rounded.
  function automatic void ref_model(input logic [W-1:0] x, output longint d_exp,
                                    output bit sat_exp, output bit near);
    longint a;
    real    ex, lim, v;
    if (x == '0) begin
      d_exp = 64'sd8388607; sat_exp = 1'b1; near = 1'b0;
      return;
    end
    a       = x[W-1] ? (longint'(1) << W) - longint'(x) : longint'(x);
    ex      = 16777216.0 / real'(a);
    lim     = x[W-1] ? 8388608.0 : 8388607.0;
    sat_exp = (ex > lim);
    near    = (ex - lim <= 1.0) && (lim - ex <= 1.0);
    v       = sat_exp ? lim : ex;
    if (x[W-1]) v = -v;
    d_exp   = longint'($rtoi($floor(v + 0.5)));
  endfunction

  task automatic run_op(input logic [W-1:0] x, input int hold, output int lat,
                        output logic [W-1:0] d, output logic s, output logic z);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); lat++; #1; end
    if (lat >= 50) chk("out_valid_timeout", 0, 1);
    d = bus.out_data; s = bus.out_sat; z = bus.out_div0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bp_data",     longint'(bus.out_data), longint'(d));
      chk("bp_valid",    longint'(bus.out_valid), 1);
      chk("bp_in_ready", longint'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("handoff_valid",    longint'(bus.out_valid), 0);
    chk("handoff_in_ready", longint'(bus.in_ready), 1);
  endtask

  initial begin
    logic [W-1:0] dx   [8] = '{24'h001000, 24'h002000, 24'hFFC000, 24'h000000,
                               24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000};
    logic [W-1:0] dexp [8] = '{24'h001000, 24'h000800, 24'hFFFC00, 24'h7FFFFF,
                               24'h7FFFFF, 24'h800000, 24'h000002, 24'hFFFFFE};
    int           dtol [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    bit           dsat [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    bit           ddv0 [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int           lat;
    logic [W-1:0] d;
    logic         s, z;
    longint       d_exp;
    bit           sat_exp, near, seen;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data",  longint'(bus.out_data), 0);
    chk("rst_out_sat",   longint'(bus.out_sat), 0);
    chk("rst_out_div0",  longint'(bus.out_div0), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(dx[i], (i == 1) ? 5 : 0, lat, d, s, z);
      chk($sformatf("dir_data_%0d", i), sx(d), sx(dexp[i]), dtol[i]);
      chk($sformatf("dir_sat_%0d", i),  longint'(s), longint'(dsat[i]));
      chk($sformatf("dir_div0_%0d", i), longint'(z), longint'(ddv0[i]));
      if (i == 0) chk("lat_nonzero", lat, 9);
      if (i == 3) chk("lat_zero", lat, 3);
    end

    // Abort in the middle of the iterations.
    bus.in_valid = 1'b1; bus.in_data = 24'h001000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_in_ready",  longint'(bus.in_ready), 1);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_out_data",  longint'(bus.out_data), 0);
    chk("midrst_out_sat",   longint'(bus.out_sat), 0);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    chk("midrst_no_stray", longint'(seen), 0);
    run_op(24'h001000, 0, lat, d, s, z);
    chk("post_rst_data", sx(d), 4096, 1);
    chk("post_rst_lat", lat, 9);

    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] mag, x;
      mag = W'($urandom) >> $urandom_range(0, 23);
      if (mag == '0) mag = W'(1);
      x = ($urandom_range(0, 1) == 1) ? (~mag + W'(1)) : mag;
      ref_model(x, d_exp, sat_exp, near);
      run_op(x, 0, lat, d, s, z);
      chk($sformatf("rnd_data_x%06h", x), sx(d), d_exp, 1);
      if (!near) chk($sformatf("rnd_sat_x%06h", x), longint'(s), longint'(sat_exp));
      chk($sformatf("rnd_div0_x%06h", x), longint'(z), 0);
      chk("rnd_lat", lat, 9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
